// File: rtl/ddr2pe_dg.sv
// Backward-pass loader: un-pools and ReLU-gates DDR gradient beats, then writes them
// into the 4-lane PE buffer using the forward write-back ch/row/pix address layout.
module ddr2pe_dg #(
    parameter int BUF_DEPTH = 256,
    parameter int ADDR_W    = $clog2(BUF_DEPTH),
    parameter int BATCH     = 4,
    parameter int DATA_W    = 8,
    parameter int DDR_W     = BATCH * DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    input  logic                      conf_pooling,
    input  logic                      conf_relu,
    input  logic [3:0]                conf_ch_num,
    input  logic [3:0]                conf_pix_num,
    input  logic [3:0]                conf_row_num,
    input  logic [DDR_W-1:0]          ddr1_data,
    input  logic                      ddr1_valid,
    output logic                      ddr1_ready,
    input  logic [DDR_W-1:0]          ddr2_data,
    input  logic                      ddr2_valid,
    output logic                      ddr2_ready,
    output logic [ADDR_W-1:0]         buf_wr_addr,
    output logic [4*BATCH*DATA_W-1:0] buf_wr_data,
    output logic [3:0]                buf_wr_en
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e state_q, state_d;
    logic   pool_q, relu_q;
    logic [3:0] ch_num_q, pix_num_q, row_num_q;
    logic [3:0] ch_q, ch_d, pix_q, pix_d, row_q, row_d;
    logic [1:0] drain_q, drain_d;
    logic mask_used, run, accept, last_beat;

    // Stage 1: address/lane computed at accept, raw beat captured alongside.
    logic                  s1_vld_q;
    logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
    logic [1:0]            s1_sel_q, s1_sel_d;
    logic [DDR_W-1:0]      s1_g_q;
    logic [4*BATCH-1:0]    s1_m_q, s1_m_d;

    // Stage 2: registered buffer write port.
    logic [ADDR_W-1:0]         wr_addr_q, wr_addr_d;
    logic [4*BATCH*DATA_W-1:0] wr_data_q, wr_data_d;
    logic [3:0]                wr_en_q, wr_en_d;

    logic unused_mask_hi;
    assign unused_mask_hi = ^ddr2_data;

    assign mask_used  = pool_q | relu_q;
    assign run        = (state_q == RUN);
    assign accept     = run && ddr1_valid && (!mask_used || ddr2_valid);
    assign last_beat  = (ch_q == ch_num_q) && (pix_q == pix_num_q) && (row_q == row_num_q);
    assign done       = (state_q == IDLE);
    assign ddr1_ready = run;
    assign ddr2_ready = run && mask_used;

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        state_d = state_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        row_d   = row_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    ch_d    = '0;
                    pix_d   = '0;
                    row_d   = '0;
                    drain_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = DRAIN;
                        drain_d = '0;
                        ch_d    = '0;
                        pix_d   = '0;
                        row_d   = '0;
                    end else if (ch_q != ch_num_q) begin
                        ch_d = ch_q + 4'd1;
                    end else begin
                        ch_d = '0;
                        if (pix_q != pix_num_q) begin
                            pix_d = pix_q + 4'd1;
                        end else begin
                            pix_d = '0;
                            row_d = row_q + 4'd1;
                        end
                    end
                end
            end
            DRAIN: begin
                // Holds done low until two cycles after the final write leaves stage 2.
                if (drain_q == 2'd2) state_d = IDLE;
                else                 drain_d = drain_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            pix_q     <= '0;
            row_q     <= '0;
            drain_q   <= '0;
            pool_q    <= 1'b0;
            relu_q    <= 1'b0;
            ch_num_q  <= '0;
            pix_num_q <= '0;
            row_num_q <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            pix_q   <= pix_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            if (state_q == IDLE && start) begin
                pool_q    <= conf_pooling;
                relu_q    <= conf_relu;
                ch_num_q  <= conf_ch_num;
                pix_num_q <= conf_pix_num;
                row_num_q <= conf_row_num;
            end
        end
    end

    always_comb begin
        s1_addr_d = '0;
        s1_addr_d[ADDR_W-1 -: 4] = ch_q;
        if (pool_q) begin
            s1_addr_d[3]   = row_q[0];
            s1_addr_d[2:0] = pix_q[2:0];
        end else begin
            s1_addr_d[3]   = row_q[1];
            s1_addr_d[2:0] = pix_q[3:1];
        end
        s1_sel_d = {row_q[0], pix_q[0]};
        s1_m_d   = '0;
        for (int b = 0; b < BATCH; b++) begin
            s1_m_d[b*4 +: 4] = ddr2_data[b*8 +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s1_sel_q  <= '0;
            s1_g_q    <= '0;
            s1_m_q    <= '0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                s1_addr_q <= s1_addr_d;
                s1_sel_q  <= s1_sel_d;
                s1_g_q    <= ddr1_data;
                s1_m_q    <= s1_m_d;
            end
        end
    end

    // Pooling scatters each element to the lanes its mask bits select; otherwise one lane.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        if (s1_vld_q) begin
            wr_addr_d = s1_addr_q;
            wr_en_d   = pool_q ? 4'b1111 : (4'b0001 << s1_sel_q);
            for (int k = 0; k < 4; k++) begin
                for (int b = 0; b < BATCH; b++) begin
                    if (pool_q) begin
                        if (s1_m_q[b*4 + k])
                            wr_data_d[(k*BATCH + b)*DATA_W +: DATA_W] = s1_g_q[b*DATA_W +: DATA_W];
                    end else if (s1_sel_q == 2'(k)) begin
                        if (!relu_q || s1_m_q[b*4 +: 4] != 4'd0)
                            wr_data_d[(k*BATCH + b)*DATA_W +: DATA_W] = s1_g_q[b*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign buf_wr_en   = wr_en_q;
    assign buf_wr_addr = wr_addr_q;
    assign buf_wr_data = wr_data_q;

endmodule

// File: tb/tb_ddr2pe_dg.sv
// Randomized bench for ddr2pe_dg: a beat-index model predicts every write, ready and done
// cycle by cycle; directed runs pin the model with hand-computed literals.
module tb_ddr2pe_dg;

    localparam int BATCH  = 4;
    localparam int DATA_W = 8;
    localparam int DDR_W  = BATCH * DATA_W;
    localparam int ADDR_W = 8;

    logic               clk, rst, start, done;
    logic               conf_pooling, conf_relu;
    logic [3:0]         conf_ch_num, conf_pix_num, conf_row_num;
    logic [DDR_W-1:0]   ddr1_data, ddr2_data;
    logic               ddr1_valid, ddr1_ready, ddr2_valid, ddr2_ready;
    logic [ADDR_W-1:0]  buf_wr_addr;
    logic [4*DDR_W-1:0] buf_wr_data;
    logic [3:0]         buf_wr_en;

    ddr2pe_dg #(.BUF_DEPTH(256), .BATCH(BATCH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .conf_pooling(conf_pooling), .conf_relu(conf_relu),
        .conf_ch_num(conf_ch_num), .conf_pix_num(conf_pix_num), .conf_row_num(conf_row_num),
        .ddr1_data(ddr1_data), .ddr1_valid(ddr1_valid), .ddr1_ready(ddr1_ready),
        .ddr2_data(ddr2_data), .ddr2_valid(ddr2_valid), .ddr2_ready(ddr2_ready),
        .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data), .buf_wr_en(buf_wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int           due;
        logic [7:0]   addr;
        logic [127:0] data;
        logic [3:0]   en;
    } wr_t;

    wr_t exp_q[$];
    int  cyc = 0;
    int  m_done_cycle = 0;
    bit  m_run = 0;
    int  m_k = 0, m_total = 0, m_ch = 1, m_pix = 1;
    bit  m_pool = 0, m_relu = 0;
    int  obs_writes = 0;
    bit  capture = 0;
    logic [3:0]   obs_en[$];
    logic [7:0]   obs_addr[$];
    logic [127:0] obs_data[$];

    function automatic wr_t model_write(input int k, input logic [31:0] g,
                                        input logic [31:0] mb, input int due);
        wr_t w;
        int ch, pix, row, sel;
        logic [3:0] nib;
        ch  = k % m_ch;
        pix = (k / m_ch) % m_pix;
        row = k / (m_ch * m_pix);
        sel = (row % 2) * 2 + (pix % 2);
        w.due  = due;
        w.addr = 8'(ch * 16 + (m_pool ? (row % 2) * 8 + (pix % 8)
                                      : ((row / 2) % 2) * 8 + ((pix / 2) % 8)));
        w.en   = m_pool ? 4'hF : 4'(1 << sel);
        w.data = '0;
        for (int lane = 0; lane < 4; lane++) begin
            for (int b = 0; b < BATCH; b++) begin
                nib = mb[b*8 +: 4];
                if (m_pool) begin
                    if (nib[lane]) w.data[(lane*BATCH + b)*8 +: 8] = g[b*8 +: 8];
                end else if (lane == sel && !(m_relu && nib == 4'd0)) begin
                    w.data[(lane*BATCH + b)*8 +: 8] = g[b*8 +: 8];
                end
            end
        end
        return w;
    endfunction

    initial begin : monitor
        wr_t w;
        bit  exp_done, exp_rdy;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                m_run = 0;
                m_done_cycle = 0;
            end else begin
                exp_done = (cyc >= m_done_cycle);
                exp_rdy  = m_run && (m_k < m_total);
                check("done", done, exp_done);
                check("ddr1_ready", ddr1_ready, exp_rdy);
                check("ddr2_ready", ddr2_ready, exp_rdy && (m_pool || m_relu));
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    w = exp_q.pop_front();
                    check("wr_en", buf_wr_en, w.en);
                    check("wr_addr", buf_wr_addr, w.addr);
                    check("wr_data", buf_wr_data, w.data);
                end else begin
                    check("no_write", buf_wr_en, 4'h0);
                end
                if (buf_wr_en != 4'h0) begin
                    obs_writes++;
                    if (capture) begin
                        obs_en.push_back(buf_wr_en);
                        obs_addr.push_back(buf_wr_addr);
                        obs_data.push_back(buf_wr_data);
                    end
                end
                if (exp_done && start) begin
                    m_pool  = conf_pooling;
                    m_relu  = conf_relu;
                    m_ch    = int'(conf_ch_num) + 1;
                    m_pix   = int'(conf_pix_num) + 1;
                    m_total = m_ch * m_pix * (int'(conf_row_num) + 1);
                    m_k     = 0;
                    m_run   = 1;
                    m_done_cycle = 1 << 30;
                end else if (exp_rdy && ddr1_valid && (!(m_pool || m_relu) || ddr2_valid)) begin
                    exp_q.push_back(model_write(m_k, ddr1_data, ddr2_data, cyc + 2));
                    m_k++;
                    if (m_k == m_total) m_done_cycle = cyc + 4;
                end
            end
            cyc++;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_mask();
        logic [31:0] r;
        for (int b = 0; b < BATCH; b++) begin
            r[b*8 +: 8] = {4'($urandom), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15))};
        end
        return r;
    endfunction

    task automatic set_conf(input bit pool, input bit relu, input int chn, input int pixn, input int rown);
        conf_pooling = pool;
        conf_relu    = relu;
        conf_ch_num  = 4'(chn);
        conf_pix_num = 4'(pixn);
        conf_row_num = 4'(rown);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, done, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_rdy1"}, ddr1_ready, 1'b0);
        check({tag, "_rdy2"}, ddr2_ready, 1'b0);
        check({tag, "_en"}, buf_wr_en, 4'h0);
        check({tag, "_addr"}, buf_wr_addr, 8'h00);
        check({tag, "_data"}, buf_wr_data, 128'h0);
    endtask

    task automatic run_random(input bit pool, input bit relu, input int chn, input int pixn,
                              input int rown, input bit v2_zero, input bit poke_start, input int p_valid);
        int n = 0;
        @(posedge clk); #1;
        set_conf(pool, relu, chn, pixn, rown);
        ddr1_valid = 1'b1;
        ddr2_valid = !v2_zero;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_writes = 0;
        set_conf(1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        while (!done && n < 3000) begin
            ddr1_valid = ($urandom_range(0, 99) < p_valid);
            ddr2_valid = v2_zero ? 1'b0 : ($urandom_range(0, 99) < p_valid);
            ddr1_data  = $urandom;
            ddr2_data  = rand_mask();
            start      = poke_start && (n == 4 || n == 9);
            @(posedge clk); #1;
            n++;
        end
        ddr1_valid = 1'b0;
        ddr2_valid = 1'b0;
        start      = 1'b0;
        check("run_completes", done, 1'b1);
        check("write_count", obs_writes, (chn + 1) * (pixn + 1) * (rown + 1));
    endtask

    // ---------------- main sequence ----------------
    logic [3:0] exp_en2 [8] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8};
    logic [7:0] exp_ad2 [8] = '{8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h10};

    initial begin
        rst = 1'b0; start = 1'b0;
        set_conf(0, 0, 0, 0, 0);
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        ddr1_data = '0; ddr2_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        // 1: pooling, two beats, mask lanes 2 then 0
        @(posedge clk); #1;
        set_conf(1, 0, 0, 1, 0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ddr1_valid = 1'b1; ddr2_valid = 1'b1;
        ddr1_data = 32'h12121212; ddr2_data = 32'h04040404;
        @(posedge clk); #1;
        ddr2_data = 32'h01010101;
        @(posedge clk); #1;
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        @(negedge clk);
        check("t1_addr0", buf_wr_addr, 8'h00);
        check("t1_en0", buf_wr_en, 4'hF);
        check("t1_data0", buf_wr_data, 128'h00000000_12121212_00000000_00000000);
        @(negedge clk);
        check("t1_addr1", buf_wr_addr, 8'h01);
        check("t1_en1", buf_wr_en, 4'hF);
        check("t1_data1", buf_wr_data, 128'h00000000_00000000_00000000_12121212);
        @(negedge clk);
        check("t1_en_after", buf_wr_en, 4'h0);
        check("t1_done_early", done, 1'b0);
        @(negedge clk);
        check("t1_done", done, 1'b1);

        // 2: no pooling, relu, 8 beats, beat 3 masked off
        @(posedge clk); #1;
        set_conf(0, 1, 1, 1, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        obs_en.delete(); obs_addr.delete(); obs_data.delete();
        capture = 1;
        for (int i = 0; i < 8; i++) begin
            ddr1_valid = 1'b1; ddr2_valid = 1'b1;
            ddr1_data  = 32'h11111111 * 32'(i + 1);
            ddr2_data  = (i == 3) ? 32'hF0F0F0F0 : 32'h01020304;
            @(posedge clk); #1;
        end
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        wait_done("t2_done");
        capture = 0;
        check("t2_count", obs_en.size(), 8);
        if (obs_en.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("t2_en%0d", i), obs_en[i], exp_en2[i]);
                check($sformatf("t2_addr%0d", i), obs_addr[i], exp_ad2[i]);
            end
            check("t2_data0", obs_data[0], 128'h00000000_00000000_00000000_11111111);
            check("t2_data3", obs_data[3], 128'h0);
            check("t2_data5", obs_data[5], 128'h00000000_66666666_00000000_00000000);
        end

        // 3: no pooling, no relu, mask stream silent
        run_random(0, 0, 2, 3, 2, 1, 0, 70);

        // 4: random configurations with independent valid gaps
        for (int r = 0; r < 6; r++) begin
            run_random(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, 0, 50);
        end

        // 5: asynchronous reset after 3 of 8 beats, then a clean rerun
        @(posedge clk); #1;
        set_conf(0, 1, 1, 1, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ddr1_valid = 1'b1; ddr2_valid = 1'b1;
            ddr1_data = 32'hA5A5A5A5; ddr2_data = 32'h0F0F0F0F;
            @(posedge clk); #1;
        end
        ddr1_valid = 1'b0; ddr2_valid = 1'b0;
        check("t5_inflight_en", buf_wr_en, 4'h1);
        check("t5_inflight_addr", buf_wr_addr, 8'h10);
        #1 rst = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        run_random(0, 1, 1, 1, 1, 0, 0, 60);

        // 6: start pulsed mid-run is ignored
        run_random(1, 0, 3, 3, 1, 0, 1, 80);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
